// File: rtl/irom_loader_pkg.sv
// Shared definitions for the instruction-ROM loader: loader FSM states and the
// NOP word substituted for any fetch outside the loaded program.
package loader_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    RUN,
    ERR
  } state_t;

  // Stream words arrive least-significant byte first.
  function automatic logic [31:0] pack_word(input logic [7:0] b3, input logic [7:0] b2,
                                            input logic [7:0] b1, input logic [7:0] b0);
    return {b3, b2, b1, b0};
  endfunction

endpackage

// File: rtl/irom_loader_if.sv
// Bundles used around the loader: the memory write/read bus between the loader
// and its storage array, and the byte-stream handshake toward the loader.
interface irom_mem_if #(
  parameter int ADDR_W = 14
) ();
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic [ADDR_W-1:0] raddr;
  logic [31:0]       rdata;

  modport master (output we, waddr, wdata, raddr, input rdata);
  modport slave  (input we, waddr, wdata, raddr, output rdata);
endinterface

interface irom_stream_if ();
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       reload;

  modport master (output in_valid, in_data, reload, input in_ready);
  modport slave  (input in_valid, in_data, reload, output in_ready);
endinterface

// File: rtl/irom_loader_array.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; visibility is controlled by the loader.
module irom_array #(
  parameter int DEPTH_WORDS = 16384
) (
  input logic       clk,
  irom_mem_if.slave mem
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (mem.we) begin
      r_mem[mem.waddr] <= mem.wdata;
    end
  end

  assign mem.rdata = r_mem[mem.raddr];

endmodule

// File: rtl/irom_loader.sv
// Boot loader: parses a counted little-endian byte stream into instruction
// memory, then releases the CPU reset and serves fetches with NOP substitution.
module irom_loader
  import loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 16384,
  parameter int ADDR_W      = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  output logic [31:0]       instr,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              cpu_rst_n,
  output logic              load_err
);

  state_t            r_state,       w_state_next;
  logic [15:0]       r_count,       w_count_next;
  logic [15:0]       r_loaded_words, w_loaded_words_next;
  logic [ADDR_W-1:0] r_word_addr,   w_word_addr_next;
  logic [1:0]        r_byte_idx,    w_byte_idx_next;
  logic [7:0]        r_b0, r_b1, r_b2;
  logic [7:0]        w_b0_next, w_b1_next, w_b2_next;
  logic              r_cpu_rst_n,   w_cpu_rst_n_next;
  logic              r_load_err,    w_load_err_next;

  logic              w_in_ready;
  logic              w_hs;
  logic [15:0]       w_hdr_n;
  logic              w_hdr_bad;
  logic              w_last_word;
  logic              w_fetch_hit;

  irom_mem_if #(.ADDR_W(ADDR_W)) w_mem ();

  irom_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk (clk),
    .mem (w_mem.slave)
  );

  // A reload request blocks acceptance in the same cycle so no byte is lost into the old stream.
  assign w_in_ready = ((r_state == HDR0) || (r_state == HDR1) || (r_state == DATA)) && !reload;
  assign w_hs       = in_valid && w_in_ready;

  assign w_hdr_n     = {in_data, r_count[7:0]};
  assign w_hdr_bad   = (w_hdr_n == 16'd0) || (32'(w_hdr_n) > 32'(DEPTH_WORDS));
  assign w_last_word = (32'(r_word_addr) + 32'd1) == 32'(r_count);

  always_comb begin
    w_state_next        = r_state;
    w_count_next        = r_count;
    w_loaded_words_next = r_loaded_words;
    w_word_addr_next    = r_word_addr;
    w_byte_idx_next     = r_byte_idx;
    w_b0_next           = r_b0;
    w_b1_next           = r_b1;
    w_b2_next           = r_b2;
    w_mem.we            = 1'b0;
    w_mem.waddr         = r_word_addr;
    w_mem.wdata         = pack_word(in_data, r_b2, r_b1, r_b0);

    if (reload) begin
      w_state_next        = HDR0;
      w_count_next        = 16'd0;
      w_loaded_words_next = 16'd0;
      w_word_addr_next    = '0;
      w_byte_idx_next     = 2'd0;
    end else begin
      case (r_state)
        HDR0: begin
          if (w_hs) begin
            w_count_next = {8'h00, in_data};
            w_state_next = HDR1;
          end
        end
        HDR1: begin
          if (w_hs) begin
            if (w_hdr_bad) begin
              w_state_next = ERR;
            end else begin
              w_count_next     = w_hdr_n;
              w_word_addr_next = '0;
              w_byte_idx_next  = 2'd0;
              w_state_next     = DATA;
            end
          end
        end
        DATA: begin
          if (w_hs) begin
            w_byte_idx_next = 2'(r_byte_idx + 2'd1);
            case (r_byte_idx)
              2'd0: w_b0_next = in_data;
              2'd1: w_b1_next = in_data;
              2'd2: w_b2_next = in_data;
              default: begin
                w_mem.we = 1'b1;
                if (w_last_word) begin
                  w_loaded_words_next = r_count;
                  w_state_next        = RUN;
                end else begin
                  w_word_addr_next = ADDR_W'(r_word_addr + 1'b1);
                end
              end
            endcase
          end
        end
        RUN:     w_state_next = RUN;
        ERR:     w_state_next = ERR;
        default: w_state_next = HDR0;
      endcase
    end

    // Registered from the next state so the CPU reset releases/asserts on the RUN entry/exit edge.
    w_cpu_rst_n_next = (w_state_next == RUN);
    w_load_err_next  = (w_state_next == ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= HDR0;
      r_count        <= 16'd0;
      r_loaded_words <= 16'd0;
      r_word_addr    <= '0;
      r_byte_idx     <= 2'd0;
      r_b0           <= 8'd0;
      r_b1           <= 8'd0;
      r_b2           <= 8'd0;
      r_cpu_rst_n    <= 1'b0;
      r_load_err     <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_count        <= w_count_next;
      r_loaded_words <= w_loaded_words_next;
      r_word_addr    <= w_word_addr_next;
      r_byte_idx     <= w_byte_idx_next;
      r_b0           <= w_b0_next;
      r_b1           <= w_b1_next;
      r_b2           <= w_b2_next;
      r_cpu_rst_n    <= w_cpu_rst_n_next;
      r_load_err     <= w_load_err_next;
    end
  end

  // Fetches outside the loaded range never reach stale memory contents.
  assign w_fetch_hit = (r_state == RUN) && (32'(pc) < 32'(r_loaded_words));
  assign w_mem.raddr = pc;
  assign instr       = w_fetch_hit ? w_mem.rdata : NOP_INSTR;

  assign in_ready  = w_in_ready;
  assign cpu_rst_n = r_cpu_rst_n;
  assign load_err  = r_load_err;

endmodule

// File: tb/tb_irom_loader.sv
// Randomized scoreboard bench for irom_loader: a program-level model predicts
// fetch results and status each cycle; a monitor compares them at the negedge.
module tb_irom_loader;
  import loader_pkg::*;

  localparam int DEPTH = 16384;
  localparam int AW    = 14;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] pc    = '0;
  logic [31:0]   instr;
  logic          cpu_rst_n;
  logic          load_err;

  irom_stream_if s ();

  always #5 clk = ~clk;

  irom_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .instr     (instr),
    .in_valid  (s.in_valid),
    .in_data   (s.in_data),
    .in_ready  (s.in_ready),
    .reload    (s.reload),
    .cpu_rst_n (cpu_rst_n),
    .load_err  (load_err)
  );

  typedef struct {
    string       name;
    int          cyc;
    logic [31:0] instr;
    logic        cpu;
    logic        err;
    logic        rdy;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  int          hs_cnt = 0;

  // Program-level model: what the CPU should see, not how the loader gets there.
  bit          m_running = 0;
  bit          m_err     = 0;
  int          m_loaded  = 0;
  logic [31:0] m_mem[int];
  logic [31:0] wq[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s.in_valid && s.in_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      chk({mon_e.name, ".instr"}, instr, mon_e.instr);
      chk({mon_e.name, ".cpu_rst_n"}, {31'd0, cpu_rst_n}, {31'd0, mon_e.cpu});
      chk({mon_e.name, ".load_err"}, {31'd0, load_err}, {31'd0, mon_e.err});
      chk({mon_e.name, ".in_ready"}, {31'd0, s.in_ready}, {31'd0, mon_e.rdy});
      $display("txn %s cyc=%0d pc=%0d instr=%h cpu=%b err=%b rdy=%b",
               mon_e.name, mon_e.cyc, pc, instr, cpu_rst_n, load_err, s.in_ready);
    end
  end

  function automatic logic [31:0] model_instr(input int p);
    if (m_running && p < m_loaded) return m_mem[p];
    return NOP_INSTR;
  endfunction

  function automatic logic [AW-1:0] rand_pc();
    if ($urandom_range(0, 7) == 0) return '1;
    return AW'($urandom_range(0, 15));
  endfunction

  // Queue the expected outcome for the inputs currently driven, then advance one cycle.
  task automatic step(input string name);
    exp_t e;
    e.name  = name;
    e.cyc   = cyc;
    e.instr = model_instr(int'(pc));
    e.cpu   = m_running;
    e.err   = m_err;
    e.rdy   = !m_running && !m_err && !s.reload;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    if (stall) begin
      s.in_valid = 1'b0;
      s.in_data  = 8'($urandom);
      pc         = rand_pc();
      step("stall");
    end
    s.in_valid = 1'b1;
    s.in_data  = b;
    pc         = rand_pc();
    step("byte");
    s.in_valid = 1'b0;
  endtask

  // mode: 0 = back-to-back, 1 = idle cycle before every byte, 2 = random idles
  task automatic load_words(input int mode);
    int n;
    bit st;
    n = wq.size();
    for (int k = 0; k < 2 + 4 * n; k++) begin
      logic [7:0] b;
      if (k == 0)      b = n[7:0];
      else if (k == 1) b = n[15:8];
      else             b = wq[(k - 2) / 4][8 * ((k - 2) % 4) +: 8];
      st = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      send_byte(b, st);
    end
    for (int i = 0; i < n; i++) m_mem[i] = wq[i];
    m_loaded  = n;
    m_running = 1;
  endtask

  task automatic do_reload(input bit with_valid);
    s.reload   = 1'b1;
    s.in_valid = with_valid;
    s.in_data  = 8'h01;
    step("reload");
    m_running  = 0;
    m_err      = 0;
    m_loaded   = 0;
    s.reload   = 1'b0;
    s.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    s.in_valid = 1'b0;
    step("rst");
    m_running  = 0;
    m_err      = 0;
    m_loaded   = 0;
    rst_n      = 1'b1;
  endtask

  task automatic run_fetches(input int k);
    for (int i = 0; i < k; i++) begin
      pc = rand_pc();
      step("fetch");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;
    s.in_valid = 1'b0;
    s.in_data  = 8'h00;
    s.reload   = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_fetches(2);

    // Two-word program, then direct fetches in and past the loaded range.
    wq = {32'h0010_0513, 32'h0020_0593};
    load_words(0);
    pc = 14'd0; step("prog2_pc0");
    pc = 14'd1; step("prog2_pc1");
    pc = 14'd2; step("prog2_pc2");
    run_fetches(4);

    // Reload while running with a byte offered in the same cycle.
    pc = 14'd0;
    do_reload(1'b1);
    run_fetches(4);

    // Zero-length header is rejected and held until reload.
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    m_err = 1;
    s.in_valid = 1'b1;
    s.in_data  = 8'h55;
    run_fetches(3);
    s.in_valid = 1'b0;
    do_reload(1'b0);
    run_fetches(1);

    // Oversized header (16641 words).
    send_byte(8'h01, 1'b0);
    send_byte(8'h41, 1'b0);
    m_err = 1;
    run_fetches(2);
    do_reload(1'b0);

    // One word with valid toggling every cycle.
    base = hs_cnt;
    wq = {32'hDEAD_BEEF};
    load_words(1);
    chk("toggle_handshakes", hs_cnt - base, 6);
    pc = 14'd0; step("toggle_pc0");
    pc = 14'd1; step("toggle_pc1");

    // Reset partway through a word, then a clean stream.
    do_reload(1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    do_reset();
    run_fetches(1);
    wq = {32'hCAFE_F00D};
    load_words(2);
    pc = 14'd0; step("after_rst_pc0");

    // Random programs with random stalls.
    for (int t = 0; t < 6; t++) begin
      do_reload(1'($urandom_range(0, 1)));
      n = $urandom_range(1, 8);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      load_words(2);
      run_fetches(8);
      pc = AW'(n - 1); step("rand_last");
      pc = AW'(n);     step("rand_past");
    end

    s.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irom_loader.md
IROM_LOADER -- requirements
Module: irom_loader

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 16384, giving instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 14, giving word-address width; DEPTH_WORDS <= 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port pc  input  ADDR_W  CPU fetch word address.
REQ-006 SHALL have port instr  output  32  fetched instruction for pc.
REQ-007 SHALL have port in_valid  input  1  loader byte valid.
REQ-008 SHALL have port in_data  input  8  loader byte.
REQ-009 SHALL have port in_ready  output  1  loader byte accepted when in_valid && in_ready.
REQ-010 SHALL have port reload  input  1  single-cycle request to restart loading.
REQ-011 SHALL have port cpu_rst_n  output  1  registered active-low reset for the CPU core.
REQ-012 SHALL have port load_err  output  1  header rejected; sticky until reload or rst_n.

Function
REQ-013 SHALL implement states HDR0, HDR1, DATA, RUN, ERR.
REQ-014 Stream format SHALL be: 16-bit word count N, little-endian (HDR0 low byte, HDR1 high byte), then 4*N bytes, each word little-endian.
REQ-015 in_ready SHALL be 1 in HDR0, HDR1 and DATA when reload=0, and 0 otherwise.
REQ-016 HDR0 -> HDR1 on handshake, latching the low count byte.
REQ-017 HDR1 on handshake: N==0 or N>DEPTH_WORDS -> ERR with load_err=1; otherwise -> DATA with word_addr=0, byte_idx=0.
REQ-018 In DATA, byte_idx 0..2 bytes SHALL be buffered; the handshake with byte_idx==3 SHALL write {in_data,b2,b1,b0} to mem[word_addr] on that edge.
REQ-019 Writing word N-1 SHALL move to RUN on the same edge, with loaded_words=N and cpu_rst_n=1 in the next cycle.
REQ-020 instr SHALL be combinational: mem[pc] when state==RUN and pc<loaded_words; otherwise 32'h00000013 (NOP). No read latency.
REQ-021 cpu_rst_n SHALL be 1 only while state==RUN; it deasserts on the same edge that leaves RUN.
REQ-022 reload=1 in any state SHALL go to HDR0 on the next edge: cpu_rst_n=0, load_err=0, loaded_words=0, counters cleared, no byte accepted that cycle.
REQ-023 ERR SHALL hold, with in_ready=0, until reload or rst_n.
REQ-024 A pc outside the loaded range in RUN SHALL return NOP; addresses SHALL not wrap.
REQ-025 A stall of in_valid between bytes SHALL not change state or counters.

Reset
REQ-026 On rst_n=0 at an edge: state=HDR0, cpu_rst_n=0, load_err=0, loaded_words=0, word_addr=0, byte_idx=0, count register=0.
REQ-027 Memory contents SHALL not be cleared by reset; loaded_words=0 makes them invisible through NOP substitution.
REQ-028 Reset in mid-DATA SHALL abandon the partial word; the next stream restarts at HDR0.

Structure
REQ-029 The NOP constant (32'h00000013) and the state enum SHALL live in the shared package loader_pkg.
REQ-030 Storage SHALL be the sub-module irom_array: one synchronous write port and one asynchronous read port, DEPTH_WORDS x 32.

Verification
REQ-031 Bytes 02 00 | 13 05 10 00 | 93 05 20 00 -> mem[0]=00100513, mem[1]=00200593; cpu_rst_n=1 the cycle after the last handshake; pc=0 gives 00100513, pc=2 gives 00000013.
REQ-032 Header 00 00 -> ERR, load_err=1, in_ready=0, cpu_rst_n stays 0; a reload pulse then clears load_err and returns in_ready=1.
REQ-033 Header 01 41 (N=16641 > 16384) -> ERR; no memory write.
REQ-034 in_valid toggled 1/0 every cycle during a 1-word load (N=1, word DEADBEEF) -> mem[0]=DEADBEEF after exactly 6 handshakes.
REQ-035 rst_n=0 after 2 data bytes of a 1-word load, then a fresh 1-word stream of CAFEF00D -> mem[0]=CAFEF00D; no stale bytes in the word.
REQ-036 reload in RUN, asserted in the same cycle as in_valid=1 -> byte not accepted, cpu_rst_n=0 next cycle, instr=00000013 for every pc until reload completes.
